// File: rtl/mips_encode_loader_pkg.sv
// Shared types and opcode constants for the MIPS instruction encoder/loader.
// Field layout: op[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6] funct[5:0].
package mips_encode_loader_pkg;

  typedef enum logic [1:0] {
    FMT_R   = 2'd0,
    FMT_I   = 2'd1,
    FMT_J   = 2'd2,
    FMT_RSV = 2'd3
  } fmt_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [5:0] OP_OTHER0 = 6'h00;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP0_ADD   = 6'h20;

endpackage

// File: rtl/mips_encode_loader_encode.sv
// Combinational field-to-word packer for R/I/J MIPS formats, plus request legality.
// Legality checking is compiled in only with ENCODE_CHECK_EN; otherwise every request is legal.
module mips_encode_loader_encode
  import mips_encode_loader_pkg::*;
(
  input  logic [1:0]  fmt,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [25:0] imm,
  output logic [31:0] word,
  output logic        legal
);

  always_comb begin
    word = '0;
    unique case (fmt_e'(fmt))
      FMT_R:   word = {opcode, rs, rt, rd, 5'b0, funct};
      FMT_I:   word = {opcode, rs, rt, imm[15:0]};
      FMT_J:   word = {opcode, imm};
      default: word = '0;  // reserved format packs as nop
    endcase
  end

`ifdef ENCODE_CHECK_EN
  always_comb begin
    legal = 1'b0;
    if (fmt_e'(fmt) == FMT_R)
      legal = (opcode == OP_OTHER0);
    else
      legal = (fmt_e'(fmt) != FMT_RSV) && (opcode != OP_OTHER0);
  end
`else
  assign legal = 1'b1;
`endif

endmodule

// File: rtl/mips_encode_loader.sv
// Encodes field-level instruction requests and writes them sequentially into imem via a small FIFO.
// Optional ENCODE_CHECK_EN: illegal requests are consumed without a write and raise a sticky error.
module mips_encode_loader
  import mips_encode_loader_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                FIFO_DEPTH = 4,
  parameter int                CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  n_instr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [5:0]        in_opcode,
  input  logic [5:0]        in_funct,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [25:0]       in_imm,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int AW = $clog2(FIFO_DEPTH);

  state_e            state, state_nxt;
  logic [CNT_W-1:0]  n_reg, acc_cnt, wr_cnt;
  logic [ADDR_W-1:0] addr_reg;
  logic [AW:0]       wr_ptr, rd_ptr;
  logic [31:0]       fifo_p1 [FIFO_DEPTH];
  logic [31:0]       enc_word_p0;
  logic              enc_legal_p0;
  logic              run, full, empty, accept, vld_p0, skip, pop, start_ok;

  // Stage p0: combinational encode of the presented request
  mips_encode_loader_encode u_encode (
    .fmt    (in_fmt),
    .opcode (in_opcode),
    .funct  (in_funct),
    .rs     (in_rs),
    .rt     (in_rt),
    .rd     (in_rd),
    .imm    (in_imm),
    .word   (enc_word_p0),
    .legal  (enc_legal_p0)
  );

  assign run      = (state == S_RUN);
  assign start_ok = start && (state != S_RUN);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign in_ready = run && !full && (acc_cnt < n_reg);
  assign accept   = in_valid && in_ready;
  assign vld_p0   = accept && enc_legal_p0;
  assign skip     = accept && !enc_legal_p0;
  assign mem_we   = run && !empty;
  assign pop      = mem_we && mem_ready;

  assign mem_addr  = addr_reg;
  assign mem_wdata = fifo_p1[rd_ptr[AW-1:0]];
  assign busy      = run;
  assign done      = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_RUN;
      S_RUN:          if (wr_cnt == n_reg) state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n_reg    <= '0;
      acc_cnt  <= '0;
      wr_cnt   <= '0;
      addr_reg <= BASE_ADDR;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else if (start_ok) begin
      n_reg    <= n_instr;
      acc_cnt  <= '0;
      wr_cnt   <= '0;
      addr_reg <= BASE_ADDR;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (accept) acc_cnt <= acc_cnt + 1'b1;
      // skipped (illegal) requests still count toward completion
      wr_cnt <= wr_cnt + CNT_W'(pop) + CNT_W'(skip);
      if (pop) begin
        addr_reg <= addr_reg + ADDR_W'(4);
        rd_ptr   <= rd_ptr + 1'b1;
      end
      if (vld_p0) wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // Stage p1: encoded word buffered; storage carries no reset
  always_ff @(posedge clk) begin
    if (vld_p0) fifo_p1[wr_ptr[AW-1:0]] <= enc_word_p0;
  end

`ifdef ENCODE_CHECK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (reset)         err_q <= 1'b0;
    else if (start_ok) err_q <= 1'b0;
    else if (skip)     err_q <= 1'b1;
  end
  assign error = err_q;
`else
  assign error = 1'b0;
`endif

endmodule
